// File: rtl/rr_grant_arbiter8.sv
// rtl/rr_grant_arbiter8.sv - 8-way round-robin arbiter with registered one-hot grant and hold timeout
module rr_grant_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  // Last cycle of a grant that would otherwise run into the hold budget.
  localparam logic [7:0] HOLD_LAST = 8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic       HOLD_EN   = (MAX_HOLD != 0);

  state_t     state, state_nx;
  logic [2:0] ptr, ptr_nx;
  logic [2:0] idx_nx;
  logic [7:0] hold_cnt, hold_nx;
  logic       valid_nx;
  logic       timeout_nx;
  logic [7:0] gnt_nx;

  logic [2:0] pick;
  logic [2:0] cand;
  logic       found;

  logic       release_done;
  logic       release_drop;
  logic       release_to;

  // Search ptr+1 .. ptr+8; the previous owner (ptr) is examined last.
  always_comb begin
    pick  = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cand = ptr + 3'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    release_done = done;
    release_drop = ~req[gnt_idx];
    release_to   = HOLD_EN && (hold_cnt == HOLD_LAST);
  end

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    idx_nx     = gnt_idx;
    hold_nx    = hold_cnt;
    valid_nx   = gnt_valid;
    timeout_nx = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = GRANT;
          idx_nx   = pick;
          ptr_nx   = pick;
          valid_nx = 1'b1;
          hold_nx  = 8'd0;
        end
      end
      GRANT: begin
        if (release_done || release_drop || release_to) begin
          state_nx   = IDLE;
          valid_nx   = 1'b0;
          timeout_nx = release_to && !release_done && !release_drop;
        end else if (hold_cnt != 8'hFF) begin
          hold_nx = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
      end
    endcase
    gnt_nx = valid_nx ? (8'd1 << idx_nx) : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd7;
      hold_cnt  <= 8'd0;
      gnt       <= 8'h00;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      hold_cnt  <= hold_nx;
      gnt       <= gnt_nx;
      gnt_idx   <= idx_nx;
      gnt_valid <= valid_nx;
      timeout   <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// tb/tb_rr_grant_arbiter8.sv - directed and randomized bench for rr_grant_arbiter8
module tb_rr_grant_arbiter8;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: who owns the resource, who owned it last, how long it has been shown.
  bit m_owned;
  int m_idx;
  int m_last;
  int m_shown;
  bit m_to;

  rr_grant_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit rd, rp, rt;
    if (!rst_n) begin
      m_owned = 0; m_idx = 0; m_last = 7; m_shown = 0; m_to = 0;
    end else if (!m_owned) begin
      m_to = 0;
      for (int k = 1; k <= 8; k++) begin
        int i;
        i = (m_last + k) % 8;
        if (!m_owned && req[i]) begin
          m_owned = 1; m_idx = i; m_last = i; m_shown = 1;
        end
      end
    end else begin
      rd = done;
      rp = !req[m_idx];
      rt = (MAX_HOLD != 0) && (m_shown == MAX_HOLD);
      if (rd || rp || rt) begin
        m_owned = 0;
        m_to = rt && !rd && !rp;
      end else begin
        m_shown++;
        m_to = 0;
      end
    end
  endtask

  task automatic step();
    logic [7:0] exp_gnt;
    @(posedge clk);
    model_edge();
    #1;
    exp_gnt = m_owned ? (8'd1 << m_idx) : 8'd0;
    check("gnt", gnt, exp_gnt);
    check("gnt_idx", {5'd0, gnt_idx}, 8'(m_idx));
    check("gnt_valid", {7'd0, gnt_valid}, {7'd0, m_owned});
    check("timeout", {7'd0, timeout}, {7'd0, m_to});
    check("onehot", 8'($countones(gnt) <= 1), 8'd1);
  endtask

  initial begin
    rst_n = 1'b0; req = 8'hFF; done = 1'b0;
    m_owned = 0; m_idx = 0; m_last = 7; m_shown = 0; m_to = 0;
    #2;
    step(); step();
    check("reset_gnt", gnt, 8'h00);
    check("reset_valid", {7'd0, gnt_valid}, 8'd0);
    check("reset_timeout", {7'd0, timeout}, 8'd0);

    rst_n = 1'b1; req = 8'h01;
    step();
    check("first_gnt", gnt, 8'h01);
    check("first_idx", {5'd0, gnt_idx}, 8'd0);

    // Full rotation with done on every grant cycle.
    req = 8'hFF;
    for (int j = 1; j <= 8; j++) begin
      done = 1'b1; step();
      check("rot_dead", gnt, 8'h00);
      done = 1'b0; step();
      check("rot_gnt", gnt, 8'd1 << (j % 8));
    end

    // Pointer wrap past idx 6.
    req = 8'h40; done = 1'b1; step();
    done = 1'b0; step();
    check("wrap_g6", gnt, 8'h40);
    done = 1'b1; step();
    done = 1'b0; req = 8'h41; step();
    check("wrap_g0", gnt, 8'h01);
    done = 1'b1; step();
    done = 1'b0; req = 8'h41; step();
    check("wrap_g6b", gnt, 8'h40);

    // Timeout release after exactly MAX_HOLD cycles.
    req = 8'h04; done = 1'b1; step();
    done = 1'b0; step();
    check("to_g1", gnt, 8'h04);
    for (int c = 2; c <= MAX_HOLD; c++) begin
      step();
      check("to_hold", gnt, 8'h04);
    end
    step();
    check("to_rel", gnt, 8'h00);
    check("to_pulse", {7'd0, timeout}, 8'd1);
    step();
    check("to_regnt", gnt, 8'h04);
    check("to_pulse_end", {7'd0, timeout}, 8'd0);
    for (int c = 2; c <= MAX_HOLD; c++) step();
    done = 1'b1; step();
    check("to_done_rel", gnt, 8'h00);
    check("to_done_nopulse", {7'd0, timeout}, 8'd0);
    done = 1'b0;

    // Owner drops its request mid-grant.
    req = 8'h08; step();
    check("drop_g3", gnt, 8'h08);
    step();
    req = 8'h20; step();
    check("drop_rel", gnt, 8'h00);
    check("drop_nopulse", {7'd0, timeout}, 8'd0);
    step();
    check("drop_g5", gnt, 8'h20);

    // Reset in the middle of a grant.
    rst_n = 1'b0; step();
    check("rst_mid_gnt", gnt, 8'h00);
    check("rst_mid_valid", {7'd0, gnt_valid}, 8'd0);
    rst_n = 1'b1; req = 8'h81; step();
    check("rst_mid_ptr", gnt, 8'h01);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      req   = 8'($urandom) & 8'($urandom);
      done  = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 59) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter8.md
Name: rr_grant_arbiter8

Overview:
- 8-way round-robin arbiter for a shared resource, with a registered one-hot grant.
- Sequences a 3-bit grant index and drives the one-hot enable vector (a 3-to-8 decode of that index), so one requester at a time owns the resource.
- Holds each grant until the owner releases it, drops its request, or exceeds a hold-time budget.
- Sits between eight requesting blocks and the shared resource's select/enable lines.

Parameters:
- MAX_HOLD, 16: maximum cycles a grant may be held before forced release; legal range 0..255; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low; one clock, sampled on the rising edge of clk
- req  input  8  request vector; req[i]=1 means requester i wants the resource
- done  input  1  release strobe from the current owner; ignored when no grant is active
- gnt  output  8  registered one-hot grant; all zeros when no grant is active
- gnt_idx  output  3  binary index of the current/last owner
- gnt_valid  output  1  high while a grant is active
- timeout  output  1  one-cycle pulse, high in the cycle after a forced (timeout) release

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0.
  - Internal pointer ptr=3'd7 (first search starts at requester 0), hold_cnt=0, state=IDLE.
- Reset takes effect at the edge, overrides every other event, and aborts an active grant with no timeout pulse.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE; outputs unchanged except timeout=0.
  - Else pick the first i in ptr+1, ptr+2, ... ptr+8 (mod 8) with req[i]=1.
  - At the next edge: state=GRANT, gnt_idx=i, gnt=1<<i, gnt_valid=1, ptr=i, hold_cnt=0.
  - Latency: req sampled at edge N gives gnt visible after edge N (one registered stage).
- GRANT, evaluated at each edge:
  - release_done = done.
  - release_drop = ~req[gnt_idx].
  - release_to = (MAX_HOLD!=0) and (hold_cnt==MAX_HOLD-1).
  - If any release condition is true: next state IDLE, gnt=0, gnt_valid=0, gnt_idx retained.
  - Otherwise hold_cnt increments, saturating at 8 bits.
  - timeout=1 for the following single cycle only if release_to and not release_done and not release_drop. Done or drop takes precedence, so there is no pulse if they coincide with release_to.
- Grant duration:
  - A timeout-released grant is visible for exactly MAX_HOLD cycles.
  - A grant released by done is visible until the edge where done is sampled high.
- Dead cycle: every release is followed by at least one IDLE cycle with gnt=0 before the next grant.
- Fairness: ptr advances only on a new grant. A requester that held a grant has lowest priority in the next search, and a sole requester is re-granted after the dead cycle.
- req changes on non-owner bits during GRANT are ignored until the next IDLE search.
- Invariant at all times: gnt == (gnt_valid ? 1<<gnt_idx : 0). Never more than one gnt bit set.
- No X propagation on outputs after the first reset edge.

Test Plan:
- Reset with req=8'hFF for 2 cycles -> gnt=00, gnt_valid=0, timeout=0. Release rst_n with req=8'h01 -> one cycle later gnt=01, gnt_idx=0, gnt_valid=1.
- req=8'hFF held, done pulsed on each grant cycle -> gnt sequence 01,02,04,...,80,01, each separated by exactly one gnt=00 cycle. No index skipped or repeated before wrap.
- Pointer wrap: after a grant to idx 6 is released, req=8'h41 -> next gnt=01 (idx 0), not 40. After that release, req=8'h41 -> gnt=40.
- MAX_HOLD=4, req=8'h04 held, done=0 -> gnt=04 for exactly 4 cycles, then gnt=00 with timeout=1 for one cycle, then gnt=04 again.
  - Repeat with done=1 on the 4th grant cycle -> release with timeout=0.
- Owner drop: grant on idx 3, req[3] deasserts mid-grant -> gnt=00 after the next edge, timeout=0. A pending req[5] is granted after one dead cycle.
- Reset mid-grant (gnt=20) -> after the reset edge all outputs are 0 and ptr=7. Then req=8'h81 -> gnt=01.
